// File: rtl/boolean_function_pkg.sv
// Opcode encoding shared by the boolean function unit and its combinational core.
package boolean_function_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_AOI21 = 3'd6;
  localparam logic [OP_W-1:0] OP_OAI21 = 3'd7;

endpackage

// File: rtl/boolean_op_comb.sv
// Purely combinational bitwise function selector; every bit lane is independent.
module boolean_op_comb
  import boolean_function_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_AOI21: y = ~((a & b) | c);
      OP_OAI21: y = ~((a | b) & c);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/boolean_function_unit.sv
// Registered boolean function stage with valid/ready handshake, result chaining,
// zero/all-ones flags and a wrapping output-handshake counter.
module boolean_function_unit
  import boolean_function_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [OP_W-1:0]  op,
  input  logic             chain_en,
  input  logic             chain_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             d_zero,
  output logic             d_ones,
  output logic [CNT_W-1:0] txn_count
);

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return ~|v;
  endfunction

  function automatic logic is_ones(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  logic             accept;
  logic             handshake;
  logic [WIDTH-1:0] last_d;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] y_p0;

  assign in_ready  = ~rst & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // A same-cycle clear forces the chained operand to zero before it is used.
  assign a_eff = chain_en ? (chain_clr ? '0 : last_d) : a;

  boolean_op_comb #(
    .WIDTH(WIDTH)
  ) u_op (
    .op(op),
    .a (a_eff),
    .b (b),
    .c (c),
    .y (y_p0)
  );

  // Stage boundary: p0 combinational result -> registered output d
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      d         <= '0;
      d_zero    <= 1'b1;
      d_ones    <= 1'b0;
      last_d    <= '0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        d         <= y_p0;
        d_zero    <= is_zero(y_p0);
        d_ones    <= is_ones(y_p0);
        last_d    <= y_p0;
        out_valid <= 1'b1;
      end else begin
        if (handshake) out_valid <= 1'b0;
        if (chain_clr) last_d <= '0;
      end
      if (handshake) txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_boolean_function_unit.sv
// Bench for boolean_function_unit: vector table plus handshake, chaining, reset and wrap sequences.
module tb_boolean_function_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c;
  logic [2:0]       op;
  logic             chain_en, chain_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             d_zero, d_ones;
  logic [CNT_W-1:0] txn_count;

  boolean_function_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .op(op), .chain_en(chain_en), .chain_clr(chain_clr),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .d_zero(d_zero),
    .d_ones(d_ones), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, c;
    logic [WIDTH-1:0] exp_d;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: compare the registered output against the oldest accepted result.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
      q.delete();
      exp_cnt = '0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("txn_count", {28'd0, txn_count}, {28'd0, exp_cnt});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid) || out_ready});
      if (out_valid && q.size() != 0) begin
        chk("d", {24'd0, d}, {24'd0, q[0]});
        chk("d_zero", {31'd0, d_zero}, {31'd0, q[0] == 8'h00});
        chk("d_ones", {31'd0, d_ones}, {31'd0, q[0] == 8'hFF});
      end
      if (out_valid && out_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] va, vb, vc,
                      input logic ce, cc, input logic [WIDTH-1:0] exp_d);
    int n = 0;
    op = o; a = va; b = vb; c = vc; chain_en = ce; chain_clr = cc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      #1 q.push_back(exp_d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; chain_en = 1'b0; chain_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd0, 8'hAA, 8'hCC, 8'hF0, 8'h88};
    vecs[1]  = '{3'd1, 8'hAA, 8'hCC, 8'hF0, 8'hEE};
    vecs[2]  = '{3'd2, 8'hAA, 8'hCC, 8'hF0, 8'h66};
    vecs[3]  = '{3'd3, 8'hAA, 8'hCC, 8'hF0, 8'h77};
    vecs[4]  = '{3'd4, 8'hAA, 8'hCC, 8'hF0, 8'h11};
    vecs[5]  = '{3'd5, 8'hAA, 8'hCC, 8'hF0, 8'h99};
    vecs[6]  = '{3'd6, 8'hAA, 8'hCC, 8'hF0, 8'h07};
    vecs[7]  = '{3'd7, 8'hAA, 8'hCC, 8'hF0, 8'h1F};
    vecs[8]  = '{3'd6, 8'hF0, 8'hCC, 8'h01, 8'h3E};
    vecs[9]  = '{3'd4, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[10] = '{3'd3, 8'h00, 8'hFF, 8'h00, 8'hFF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; op = '0; chain_en = 1'b0; chain_clr = 1'b0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_d", {24'd0, d}, 32'h00);
    chk("reset_d_zero", {31'd0, d_zero}, 32'd1);
    chk("reset_d_ones", {31'd0, d_ones}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, 1'b0, vecs[i].exp_d);
    idle(2);

    // Backpressure: X held for 5 cycles, then X drains and Y enters together
    out_ready = 1'b0;
    send(3'd1, 8'h12, 8'h40, 8'h00, 1'b0, 1'b0, 8'h52);
    fork
      send(3'd0, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h3C);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_d_hold", {24'd0, d}, 32'h52);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(2);

    // Chaining: clear alone, then 0F, 00, 0F, and a same-cycle clear gives 0F
    chain_clr = 1'b1;
    idle(1);
    chain_clr = 1'b0;
    send(3'd2, 8'hAA, 8'h0F, 8'h00, 1'b1, 1'b0, 8'h0F);
    send(3'd2, 8'hAA, 8'h0F, 8'h00, 1'b1, 1'b0, 8'h00);
    send(3'd2, 8'hAA, 8'h0F, 8'h00, 1'b1, 1'b0, 8'h0F);
    send(3'd2, 8'hAA, 8'h0F, 8'h00, 1'b1, 1'b1, 8'h0F);
    idle(2);

    // Reset while a result is stalled; the input offered under reset must vanish
    out_ready = 1'b0;
    send(3'd1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 8'h5A);
    rst = 1'b1; in_valid = 1'b1; op = 3'd1; a = 8'hC3; b = 8'h00;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'h00);
    chk("rst_txn_count", {28'd0, txn_count}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Counter wrap: 17 back-to-back handshakes from zero
    for (int i = 1; i <= 17; i++)
      send(3'd0, 8'(i), 8'hFF, 8'h00, 1'b0, 1'b0, 8'(i));
    idle(3);
    @(negedge clk);
    chk("wrap_final", {28'd0, txn_count}, 32'd1);
    chk("drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boolean_function_unit.md
Name: boolean_function_unit

Overview:
Parametrised, registered successor to the single-bit three-input boolean gate. Applies one of eight opcode-selected bitwise functions to WIDTH-bit operands a, b and c. Results pass through one output register with a valid/ready handshake. Also provides a chaining mode that feeds the previous result back in as operand a, a transaction counter, and registered zero/all-ones flags. Used as the generic logic stage between lab datapath blocks.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of the transaction counter (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  unit can accept this cycle
a  in  WIDTH  operand a
b  in  WIDTH  operand b
c  in  WIDTH  operand c
op  in  3  function select
chain_en  in  1  replace a with last result (sampled with transaction)
chain_clr  in  1  clear last-result register
out_valid  out  1  d valid
out_ready  in  1  consumer accepts d
d  out  WIDTH  registered result
d_zero  out  1  registered: d == 0
d_ones  out  1  registered: d == all ones
txn_count  out  CNT_W  completed output handshakes, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset state (rst high at an edge): out_valid=0, d=0, d_zero=1, d_ones=0, last_d=0, txn_count=0.
- in_ready = ~rst & (~out_valid | out_ready), combinational. Inputs presented while rst is high are never accepted.
- Accept: in_valid & in_ready. On accept, these load at the next edge: d=f(op, a_eff, b, c), d_zero, d_ones, last_d=d_new, and out_valid=1.
- a_eff = chain_en ? (chain_clr ? 0 : last_d) : a.
- Opcodes:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XNOR: ~(a^b)
  - 6 AOI21: ~((a&b)|c)
  - 7 OAI21: ~((a|b)&c)
- c is ignored for opcodes 0-5.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle when out_ready=1.
- Output handshake: out_valid & out_ready. If no accept in the same cycle, out_valid->0 next edge and d holds its old value. Simultaneous handshake and accept: out_valid stays 1 and the new d loads.
- Backpressure: while out_valid & ~out_ready, d, d_zero, d_ones and out_valid hold stable and in_ready=0.
- chain_clr without accept: last_d->0 next edge.
- chain_clr with accept: the operand uses 0, and last_d takes the new result.
- txn_count increments by 1 on each output handshake. Wraps from 2^CNT_W-1 to 0. No saturation.
- Reset mid-operation: a pending result is discarded with no handshake counted, and all state returns to reset values.
- Bitwise logic only: no carries, and every lane is independent.

Decomposition:
- Package boolean_function_pkg holds the opcode constants OP_AND..OP_OAI21 (3-bit) and OP_W=3.
- One combinational sub-module, boolean_op_comb (parameter WIDTH): inputs op, a, b, c; output y.
- The top level holds the handshake, output register, chain register and counter.

Test Plan:
- Opcode sweep, WIDTH=8, a=AA, b=CC, c=F0, out_ready=1: expected d per op 0-7 is 88, EE, 66, 77, 11, 99, 07, 1F, each 1 cycle after accept. d_zero=0 and d_ones=0 throughout.
- AOI21 with a=F0, b=CC, c=01: d=3E. Then a=FF, b=FF, c=00, op=4 (NOR): d=00 and d_zero=1. Then op=3 (NAND) with a=00: d=FF and d_ones=1.
- Backpressure: out_ready=0, issue X then Y. X is accepted, in_ready drops, and d holds X for 5 cycles with txn_count=0. Raise out_ready: X handshakes, Y is accepted in the same cycle, next cycle d=Y, and txn_count=1.
- Chaining: op=2, b=0F, chain_en=1 for 3 transactions after chain_clr gives d=0F, 00, 0F. Assert chain_clr with the 4th transaction: d=0F.
- Counter wrap, CNT_W=4: 17 back-to-back handshakes give txn_count sequence 1..15, 0, 1.
- Reset mid-operation: hold out_valid=1 with out_ready=0, then pulse rst for 1 cycle while in_valid=1. Next cycle out_valid=0, d=00, txn_count=0, and in_ready=0 during the rst cycle. The input presented during rst never appears on d.
